// File: rtl/master_interface.sv
// AXI-Lite master front end: turns single user read/write requests into handshaken
// single-beat AXI-Lite transactions, with independent read/write FSMs and per-channel timeout.
module master_interface #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  // user read side
  input  logic                 USR_RD_REQ,
  input  logic [REG_WIDTH-1:0] USR_RD_ADDR,
  output logic                 USR_RD_BUSY,
  output logic [REG_WIDTH-1:0] USR_RD_DATA,
  output logic                 USR_RD_DONE,
  output logic                 USR_RD_ERR,
  // user write side
  input  logic                 USR_WR_REQ,
  input  logic [REG_WIDTH-1:0] USR_WR_ADDR,
  input  logic [REG_WIDTH-1:0] USR_WR_DATA,
  output logic                 USR_WR_BUSY,
  output logic                 USR_WR_DONE,
  output logic                 USR_WR_ERR,
  // AXI-Lite read channels
  output logic [REG_WIDTH-1:0] ARADDR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [REG_WIDTH-1:0] RDATA,
  input  logic                 RVALID,
  output logic                 RREADY,
  // AXI-Lite write channels
  output logic [REG_WIDTH-1:0] AWADDR,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [REG_WIDTH-1:0] WDATA,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic                 BVALID,
  output logic                 BREADY
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_ADDR_DATA = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [1:0]           rd_state_q, rd_state_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [REG_WIDTH-1:0] araddr_q, araddr_d;
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 rd_busy_q, rd_busy_d;
  logic                 rd_done_q, rd_done_d;
  logic                 rd_err_q, rd_err_d;
  logic                 rd_timeout;

  assign rd_timeout = (rd_cnt_q == CNT_LAST);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    araddr_d   = araddr_q;
    rd_data_d  = rd_data_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_busy_d  = rd_busy_q;
    rd_done_d  = 1'b0;
    rd_err_d   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (USR_RD_REQ) begin
          araddr_d   = USR_RD_ADDR;
          arvalid_d  = 1'b1;
          rd_busy_d  = 1'b1;
          rd_cnt_d   = '0;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        // Address acceptance does not complete the transaction, so timeout wins here.
        if (rd_timeout) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b0;
          rd_data_d  = '0;
          rd_done_d  = 1'b1;
          rd_err_d   = 1'b1;
          rd_busy_d  = 1'b0;
          rd_state_d = R_IDLE;
        end else if (arvalid_q && ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (rready_q && RVALID) begin
          rd_data_d  = RDATA;
          rready_d   = 1'b0;
          rd_done_d  = 1'b1;
          rd_busy_d  = 1'b0;
          rd_state_d = R_IDLE;
        end else if (rd_timeout) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b0;
          rd_data_d  = '0;
          rd_done_d  = 1'b1;
          rd_err_d   = 1'b1;
          rd_busy_d  = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: begin
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        rd_busy_d  = 1'b0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      araddr_q   <= '0;
      rd_data_q  <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      araddr_q   <= araddr_d;
      rd_data_q  <= rd_data_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_busy_q  <= rd_busy_d;
      rd_done_q  <= rd_done_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [1:0]           wr_state_q, wr_state_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [REG_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 wr_busy_q, wr_busy_d;
  logic                 wr_done_q, wr_done_d;
  logic                 wr_err_q, wr_err_d;
  logic                 wr_timeout;
  logic                 aw_pend, w_pend;

  assign wr_timeout = (wr_cnt_q == CNT_LAST);
  // Channels still owed a handshake after this edge.
  assign aw_pend    = awvalid_q && !AWREADY;
  assign w_pend     = wvalid_q && !WREADY;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wr_busy_d  = wr_busy_q;
    wr_done_d  = 1'b0;
    wr_err_d   = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (USR_WR_REQ) begin
          awaddr_d   = USR_WR_ADDR;
          wdata_d    = USR_WR_DATA;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_busy_d  = 1'b1;
          wr_cnt_d   = '0;
          wr_state_d = W_ADDR_DATA;
        end
      end
      W_ADDR_DATA: begin
        wr_cnt_d = wr_cnt_q + CNT_ONE;
        if (wr_timeout) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b0;
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_err_d   = 1'b1;
          wr_busy_d  = 1'b0;
          wr_state_d = W_IDLE;
        end else begin
          awvalid_d = aw_pend;
          wvalid_d  = w_pend;
          if (!aw_pend && !w_pend) begin
            bready_d   = 1'b1;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        wr_cnt_d = wr_cnt_q + CNT_ONE;
        if (bready_q && BVALID) begin
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_busy_d  = 1'b0;
          wr_state_d = W_IDLE;
        end else if (wr_timeout) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b0;
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_err_d   = 1'b1;
          wr_busy_d  = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: begin
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
        wr_busy_d  = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_busy_q  <= wr_busy_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign USR_RD_BUSY = rd_busy_q;
  assign USR_RD_DATA = rd_data_q;
  assign USR_RD_DONE = rd_done_q;
  assign USR_RD_ERR  = rd_err_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

  assign USR_WR_BUSY = wr_busy_q;
  assign USR_WR_DONE = wr_done_q;
  assign USR_WR_ERR  = wr_err_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;

endmodule

// File: tb/tb_master_interface.sv
// Directed bench for master_interface: hand-computed expectations, sampled 1 time unit
// after each rising edge.
module tb_master_interface;

  logic        ACLK;
  logic        ARESETN;
  logic        USR_RD_REQ;
  logic [31:0] USR_RD_ADDR;
  logic        USR_RD_BUSY;
  logic [31:0] USR_RD_DATA;
  logic        USR_RD_DONE;
  logic        USR_RD_ERR;
  logic        USR_WR_REQ;
  logic [31:0] USR_WR_ADDR;
  logic [31:0] USR_WR_DATA;
  logic        USR_WR_BUSY;
  logic        USR_WR_DONE;
  logic        USR_WR_ERR;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;

  int n_total;
  int n_bad;

  master_interface #(
    .REG_WIDTH(32),
    .TIMEOUT  (16)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .USR_RD_REQ (USR_RD_REQ),
    .USR_RD_ADDR(USR_RD_ADDR),
    .USR_RD_BUSY(USR_RD_BUSY),
    .USR_RD_DATA(USR_RD_DATA),
    .USR_RD_DONE(USR_RD_DONE),
    .USR_RD_ERR (USR_RD_ERR),
    .USR_WR_REQ (USR_WR_REQ),
    .USR_WR_ADDR(USR_WR_ADDR),
    .USR_WR_DATA(USR_WR_DATA),
    .USR_WR_BUSY(USR_WR_BUSY),
    .USR_WR_DONE(USR_WR_DONE),
    .USR_WR_ERR (USR_WR_ERR),
    .ARADDR     (ARADDR),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RDATA      (RDATA),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .AWADDR     (AWADDR),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .WDATA      (WDATA),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .BVALID     (BVALID),
    .BREADY     (BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    ARESETN     = 1'b0;
    USR_RD_REQ  = 1'b0;
    USR_RD_ADDR = '0;
    USR_WR_REQ  = 1'b0;
    USR_WR_ADDR = '0;
    USR_WR_DATA = '0;
    ARREADY     = 1'b0;
    RDATA       = '0;
    RVALID      = 1'b0;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    step();
    step();

    // reset state
    check_eq("rst_outputs", {USR_RD_BUSY, USR_RD_DONE, USR_RD_ERR, USR_WR_BUSY, USR_WR_DONE,
                             USR_WR_ERR, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 32'h0);
    check_eq("rst_rd_data", USR_RD_DATA, 32'h0);
    check_eq("rst_addrs", ARADDR | AWADDR | WDATA, 32'h0);
    ARESETN = 1'b1;
    step();

    // minimum-latency read
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hDEADBEEF;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h10;
    step();
    USR_RD_REQ = 1'b0;
    check_eq("rd_accept", {ARVALID, USR_RD_BUSY, RREADY}, 32'b110);
    check_eq("rd_araddr", ARADDR, 32'h10);
    step();
    check_eq("rd_ar_hs", {ARVALID, RREADY, USR_RD_DONE}, 32'b010);
    step();
    check_eq("rd_done", {USR_RD_DONE, USR_RD_ERR, USR_RD_BUSY, RREADY}, 32'b1000);
    check_eq("rd_data", USR_RD_DATA, 32'hDEADBEEF);
    step();
    check_eq("rd_done_pulse", USR_RD_DONE, 32'h0);
    check_eq("rd_data_held", USR_RD_DATA, 32'hDEADBEEF);
    ARREADY = 1'b0; RVALID = 1'b0;

    // write, WREADY two cycles before AWREADY
    USR_WR_REQ = 1'b1; USR_WR_ADDR = 32'h20; USR_WR_DATA = 32'hA5A5A5A5;
    step();
    USR_WR_REQ = 1'b0;
    check_eq("wr_accept", {AWVALID, WVALID, USR_WR_BUSY, BREADY}, 32'b1110);
    check_eq("wr_awaddr", AWADDR, 32'h20);
    check_eq("wr_wdata", WDATA, 32'hA5A5A5A5);
    WREADY = 1'b1;
    step();
    WREADY = 1'b0;
    check_eq("wr_w_first", {AWVALID, WVALID, BREADY}, 32'b100);
    step();
    check_eq("wr_aw_hold", {AWVALID, WVALID, BREADY}, 32'b100);
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    check_eq("wr_aw_hs", {AWVALID, WVALID, BREADY, USR_WR_DONE}, 32'b0010);
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    check_eq("wr_done", {USR_WR_DONE, USR_WR_ERR, USR_WR_BUSY, BREADY}, 32'b1000);
    step();
    check_eq("wr_done_pulse", USR_WR_DONE, 32'h0);

    // read timeout: RVALID never comes, DONE 16 edges after REQ
    ARREADY = 1'b1; RVALID = 1'b0;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h40;
    step();
    USR_RD_REQ = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("rdto_pre", {USR_RD_DONE, USR_RD_BUSY, RREADY}, 32'b011);
    step();
    check_eq("rdto_done", {USR_RD_DONE, USR_RD_ERR, USR_RD_BUSY, RREADY, ARVALID}, 32'b11000);
    check_eq("rdto_data", USR_RD_DATA, 32'h0);
    step();
    check_eq("rdto_pulse", {USR_RD_DONE, USR_RD_ERR}, 32'b00);

    // simultaneous read and write, second read request while busy
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'h12345678;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h30;
    USR_WR_REQ = 1'b1; USR_WR_ADDR = 32'h34; USR_WR_DATA = 32'h5555AAAA;
    step();
    USR_WR_REQ = 1'b0;
    USR_RD_ADDR = 32'h44;
    check_eq("sim_busy", {USR_RD_BUSY, USR_WR_BUSY, ARVALID, AWVALID, WVALID}, 32'b11111);
    step();
    USR_RD_REQ = 1'b0;
    check_eq("sim_ignore_addr", ARADDR, 32'h30);
    check_eq("sim_mid", {RREADY, BREADY, ARVALID, AWVALID, WVALID}, 32'b11000);
    step();
    check_eq("sim_done", {USR_RD_DONE, USR_RD_ERR, USR_WR_DONE, USR_WR_ERR}, 32'b1010);
    check_eq("sim_rd_data", USR_RD_DATA, 32'h12345678);
    step();
    check_eq("sim_2nd_ignored", {USR_RD_BUSY, ARVALID, USR_WR_BUSY}, 32'b000);
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;

    // reset in R_DATA
    RVALID = 1'b0;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h50;
    step();
    USR_RD_REQ = 1'b0;
    step();
    check_eq("rst_mid_state", {RREADY, USR_RD_BUSY}, 32'b11);
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    check_eq("rst_mid_outs", {USR_RD_BUSY, USR_RD_DONE, USR_RD_ERR, ARVALID, RREADY}, 32'b0);
    check_eq("rst_mid_data", USR_RD_DATA | ARADDR, 32'h0);
    step();
    check_eq("rst_mid_nodone", USR_RD_DONE, 32'h0);
    RVALID = 1'b1; RDATA = 32'hCAFEF00D;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h60;
    step();
    USR_RD_REQ = 1'b0;
    step();
    step();
    check_eq("rst_new_rd_done", {USR_RD_DONE, USR_RD_ERR}, 32'b10);
    check_eq("rst_new_rd_data", USR_RD_DATA, 32'hCAFEF00D);
    step();

    // RVALID on the edge where the counter reaches TIMEOUT-1: handshake wins
    RVALID = 1'b0; RDATA = 32'h0BADCAFE;
    USR_RD_REQ = 1'b1; USR_RD_ADDR = 32'h70;
    step();
    USR_RD_REQ = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    check_eq("race_pre", {USR_RD_DONE, RREADY}, 32'b01);
    RVALID = 1'b1;
    step();
    RVALID = 1'b0;
    check_eq("race_done", {USR_RD_DONE, USR_RD_ERR, USR_RD_BUSY}, 32'b100);
    check_eq("race_data", USR_RD_DATA, 32'h0BADCAFE);
    ARREADY = 1'b0;

    // write timeout: AWREADY never comes
    WREADY = 1'b1;
    USR_WR_REQ = 1'b1; USR_WR_ADDR = 32'h80; USR_WR_DATA = 32'h1;
    step();
    USR_WR_REQ = 1'b0;
    step();
    WREADY = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_eq("wrto_pre", {USR_WR_DONE, AWVALID, WVALID, USR_WR_BUSY}, 32'b0101);
    step();
    check_eq("wrto_done", {USR_WR_DONE, USR_WR_ERR, AWVALID, WVALID, BREADY, USR_WR_BUSY},
             32'b110000);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/master_interface.md
# master_interface

AXI-Lite master front end that sits directly upstream of the slave interface block and drives its read-address, read-data, write-address, write-data and write-response channels. A simple user-side request/done port is converted into fully handshaken AXI-Lite single-beat transactions. Independent read and write state machines run concurrently. A per-channel timeout aborts a transaction that the slave never completes.

## Interface
- REG_WIDTH, 32, address and data width on both the AXI and user sides
- TIMEOUT, 16, maximum busy cycles per transaction before abort; legal range 2..65535
- ACLK  input  1  clock; all logic on its rising edge
- ARESETN  input  1  synchronous, active-low reset
- USR_RD_REQ  input  1  read request; sampled only while USR_RD_BUSY=0
- USR_RD_ADDR  input  REG_WIDTH  read address; captured with USR_RD_REQ
- USR_RD_BUSY  output  1  read FSM not idle
- USR_RD_DATA  output  REG_WIDTH  last read data; held until the next USR_RD_DONE
- USR_RD_DONE  output  1  one-cycle pulse at read completion
- USR_RD_ERR  output  1  with USR_RD_DONE: 1 means timeout abort
- USR_WR_REQ  input  1  write request; sampled only while USR_WR_BUSY=0
- USR_WR_ADDR  input  REG_WIDTH  write address; captured with USR_WR_REQ
- USR_WR_DATA  input  REG_WIDTH  write data; captured with USR_WR_REQ
- USR_WR_BUSY  output  1  write FSM not idle
- USR_WR_DONE  output  1  one-cycle pulse at write completion
- USR_WR_ERR  output  1  with USR_WR_DONE: 1 means timeout abort
- ARADDR  output  REG_WIDTH / ARVALID output 1 / ARREADY input 1  read address channel
- RDATA  input  REG_WIDTH / RVALID input 1 / RREADY output 1  read data channel
- AWADDR  output  REG_WIDTH / AWVALID output 1 / AWREADY input 1  write address channel
- WDATA  output  REG_WIDTH / WVALID output 1 / WREADY input 1  write data channel
- BVALID  input  1 / BREADY output 1  write response channel

## Operation
- All outputs are registered. Reset (ARESETN=0 at an edge) sets every output to 0, sets both FSMs to idle and clears both counters. Reset mid-transaction aborts without a DONE pulse.
- Read FSM states are R_IDLE, R_ADDR and R_DATA.
  - R_IDLE: when USR_RD_REQ=1, latch ARADDR, set ARVALID=1, BUSY=1, clear the counter and go to R_ADDR.
  - R_ADDR: hold ARVALID and ARADDR stable. On an edge with ARVALID&ARREADY, set ARVALID=0, RREADY=1 and go to R_DATA.
  - R_DATA: on an edge with RVALID&RREADY, capture RDATA into USR_RD_DATA, set RREADY=0, pulse DONE with ERR=0, set BUSY=0 and go to R_IDLE.
- Write FSM states are W_IDLE, W_ADDR_DATA and W_RESP.
  - W_IDLE: when USR_WR_REQ=1, latch AWADDR and WDATA, set AWVALID=WVALID=1, BUSY=1 and clear the counter.
  - W_ADDR_DATA: AWVALID drops on its own handshake and WVALID on its own, in either order or together. When both are done, set BREADY=1 and go to W_RESP.
  - W_RESP: on BVALID&BREADY, set BREADY=0, pulse DONE with ERR=0 and return to W_IDLE.
- Timeout: each FSM's counter increments every cycle while not idle.
  - If the counter equals TIMEOUT-1 at an edge with no completing handshake, drop all of that channel's VALID/READY outputs, pulse DONE with ERR=1 and return to idle.
  - On a read timeout, USR_RD_DATA is set to 0.
  - A completing handshake on the same edge wins over the timeout.
- Requests while BUSY=1 are ignored, not queued. Read and write requests in the same cycle are both accepted.
- Counter width is clog2(TIMEOUT); no wrap-around is reachable.

## Timing
- USR_RD_REQ sampled at edge N gives ARVALID=1 from edge N to the edge where the handshake occurs.
- With ARREADY=1 at N+1 and RVALID=1 at N+2, USR_RD_DONE is high for exactly the cycle after N+2. This 3-edge read is the minimum latency.
- Minimum write latency is also 3 edges: AW/W handshakes at N+1 and B handshake at N+2.
- BUSY deasserts on the same edge DONE asserts. A new REQ is accepted at the next edge, so back-to-back transactions have a 1-cycle idle gap.
- VALID outputs never drop before their handshake except on timeout or reset.

## Test plan
- Read, ARREADY and RVALID tied 1, address 0x10, RDATA=0xDEADBEEF -> DONE 3 edges after REQ, USR_RD_DATA=0xDEADBEEF, ERR=0.
- Write 0xA5A5A5A5 to 0x20, WREADY 2 cycles before AWREADY, BVALID 1 cycle later -> WVALID drops first, AWVALID holds, then DONE with ERR=0.
- Read with RVALID never asserted, TIMEOUT=16 -> DONE with ERR=1 exactly 16 cycles after REQ, RREADY=0, USR_RD_DATA=0.
- Simultaneous read and write requests, plus a second USR_RD_REQ while busy -> both transactions complete independently and the second read is ignored.
- ARESETN=0 for one edge during R_DATA -> all outputs 0 next cycle, no DONE, and a new read succeeds afterwards.
- RVALID arriving on the same edge the counter reaches TIMEOUT-1 -> ERR=0 and the data is captured.
